// File: rtl/dso_spi_pkg.sv
// dso_spi_pkg: shared states, target/requester encodings and SS decode for the DSO SPI arbiter
package dso_spi_pkg;
    typedef enum logic [2:0] {IDLE, REJECT, SETUP, XFER, HOLD, GAP} state_t;
    localparam logic [2:0] TGT_CH1  = 3'd0;
    localparam logic [2:0] TGT_CH2  = 3'd1;
    localparam logic [2:0] TGT_CH3  = 3'd2;
    localparam logic [2:0] TGT_TRIG = 3'd3;
    localparam logic [2:0] TGT_EEP  = 3'd4;
    localparam int REQ_CAL = 0;
    localparam int REQ_CMD = 1;
    localparam int REQ_POT = 2;
    function automatic logic [4:0] ss_decode(input logic [2:0] tgt);
        return ~(5'b00001 << tgt);
    endfunction
endpackage

// File: rtl/rr_arb3.sv
// rr_arb3: combinational 3-way round-robin picker, first set request at or after ptr wins
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win,
    output logic       valid
);
    logic [2:0] rot, pick;
    assign rot   = ptr == 2'd1 ? {req[0], req[2:1]} : ptr == 2'd2 ? {req[1:0], req[2]} : req;
    assign pick  = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    assign win   = ptr == 2'd1 ? {pick[1:0], pick[2]} : ptr == 2'd2 ? {pick[0], pick[2:1]} : pick;
    assign valid = |req;
endmodule

// File: rtl/spi_bus_arb.sv
// spi_bus_arb: round-robin sharing of one SPI master among three requesters with SS setup/hold/gap sequencing
module spi_bus_arb
    import dso_spi_pkg::*;
#(
    parameter int SETUP_CYC   = 4,
    parameter int HOLD_CYC    = 4,
    parameter int GAP_CYC     = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [8:0]  req_tgt,
    input  logic [47:0] req_data,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rdata,
    output logic        ch1_ss_n,
    output logic        ch2_ss_n,
    output logic        ch3_ss_n,
    output logic        trig_ss_n,
    output logic        EEP_ss_n
);
    state_t      state;
    logic [1:0]  ptr;
    logic [2:0]  tgt, win, sel_tgt;
    logic        win_v;
    logic [7:0]  cnt;
    logic [15:0] tcnt, sel_data;
    logic [4:0]  ss_n;

    rr_arb3 u_arb (.req(req), .ptr(ptr), .win(win), .valid(win_v));

    assign sel_tgt  = win[2] ? req_tgt[8:6] : win[1] ? req_tgt[5:3] : req_tgt[2:0];
    assign sel_data = win[2] ? req_data[47:32] : win[1] ? req_data[31:16] : req_data[15:0];
    assign {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n} = ss_n;

    // Arbitration FSM: grant one cycle ahead of SS so owner and select never change together
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            tgt     <= 3'd0;
            cnt     <= 8'd0;
            tcnt    <= 16'd0;
            gnt     <= 3'b000;
            done    <= 3'b000;
            err     <= 1'b0;
            busy    <= 1'b0;
            spi_wrt <= 1'b0;
            rdata   <= 16'd0;
            spi_cmd <= 16'd0;
            ss_n    <= 5'h1f;
        end else begin
            done    <= 3'b000;
            err     <= 1'b0;
            spi_wrt <= 1'b0;
            case (state)
                IDLE: if (win_v) begin
                    gnt     <= win;
                    tgt     <= sel_tgt;
                    spi_cmd <= sel_data;
                    ptr     <= win[0] ? 2'd1 : win[1] ? 2'd2 : 2'd0;
                    cnt     <= 8'd0;
                    busy    <= 1'b1;
                    state   <= sel_tgt <= TGT_EEP ? SETUP : REJECT;
                end
                REJECT: begin
                    done  <= gnt;
                    err   <= 1'b1;
                    gnt   <= 3'b000;
                    cnt   <= 8'd1;
                    state <= GAP;
                end
                SETUP: begin
                    ss_n <= ss_decode(tgt);
                    cnt  <= cnt + 8'd1;
                    if (cnt == 8'(SETUP_CYC)) begin
                        spi_wrt <= 1'b1;
                        tcnt    <= 16'd0;
                        state   <= XFER;
                    end
                end
                XFER: if (spi_done) begin
                    rdata <= spi_rdata;
                    cnt   <= 8'd1;
                    state <= HOLD;
                end else if (tcnt == 16'(TIMEOUT_CYC - 1)) begin
                    ss_n  <= 5'h1f;
                    done  <= gnt;
                    err   <= 1'b1;
                    gnt   <= 3'b000;
                    cnt   <= 8'd1;
                    state <= GAP;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
                HOLD: if (cnt == 8'(HOLD_CYC)) begin
                    ss_n  <= 5'h1f;
                    done  <= gnt;
                    gnt   <= 3'b000;
                    cnt   <= 8'd1;
                    state <= GAP;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                GAP: if (cnt == 8'(GAP_CYC)) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_bus_arb.sv
// tb_spi_bus_arb: directed self-checking bench for the SPI bus arbiter
module tb_spi_bus_arb;
    localparam int SETUP_CYC   = 4;
    localparam int HOLD_CYC    = 4;
    localparam int GAP_CYC     = 8;
    localparam int TIMEOUT_CYC = 4096;

    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  req = '0;
    logic [8:0]  req_tgt = '0;
    logic [47:0] req_data = '0;
    logic [2:0]  gnt, done;
    logic        err, busy, spi_wrt;
    logic [15:0] rdata, spi_cmd;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rdata = '0;
    logic        ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n;
    logic [4:0]  ss;
    int errors = 0, checks = 0;

    assign ss = {EEP_ss_n, trig_ss_n, ch3_ss_n, ch2_ss_n, ch1_ss_n};

    always #5 clk = ~clk;

    spi_bus_arb #(.SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tgt(req_tgt), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rdata(spi_rdata),
        .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n),
        .trig_ss_n(trig_ss_n), .EEP_ss_n(EEP_ss_n)
    );

    task automatic wait_wrt(output int n);
        n = 0;
        while (spi_wrt !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done === 3'b000 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic spi_frame(input int lat, input logic [15:0] rd);
        repeat (lat) @(negedge clk);
        spi_rdata = rd;
        spi_done  = 1'b1;
        @(negedge clk);
        spi_done  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait: busy=%b required 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, done, err, busy, spi_wrt} !== 9'd0) begin errors++; $display("FAIL reset_ctl: got %b required 0", {gnt, done, err, busy, spi_wrt}); end
        checks++;
        if ({rdata, spi_cmd} !== 32'd0) begin errors++; $display("FAIL reset_data: got %h required 0", {rdata, spi_cmd}); end
        checks++;
        if (ss !== 5'h1f) begin errors++; $display("FAIL reset_ss: got %h required 1f", ss); end
    endtask

    task automatic test_single_pot();
        int n, low, hn;
        req = 3'b100; req_tgt[8:6] = 3'd1; req_data[47:32] = 16'h1234;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b100 || ss !== 5'h1f) begin errors++; $display("FAIL pot_grant: gnt=%b ss=%h required 100/1f", gnt, ss); end
        n = 0; low = 0;
        while (spi_wrt !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (ss === 5'h1d && spi_wrt !== 1'b1) low++;
        end
        checks++;
        if (low != SETUP_CYC || n != SETUP_CYC + 1) begin errors++; $display("FAIL pot_setup: low=%0d n=%0d required %0d/%0d", low, n, SETUP_CYC, SETUP_CYC + 1); end
        checks++;
        if (spi_cmd !== 16'h1234 || ss !== 5'h1d) begin errors++; $display("FAIL pot_cmd: cmd=%h ss=%h required 1234/1d", spi_cmd, ss); end
        spi_frame(3, 16'habcd);
        checks++;
        if (ss !== 5'h1d || spi_wrt !== 1'b0) begin errors++; $display("FAIL pot_hold_ss: ss=%h wrt=%b required 1d/0", ss, spi_wrt); end
        wait_done(20, hn);
        req = 3'b000;
        checks++;
        if (hn != HOLD_CYC) begin errors++; $display("FAIL pot_hold_len: got %0d required %0d", hn, HOLD_CYC); end
        checks++;
        if (done !== 3'b100 || err !== 1'b0 || gnt !== 3'b000 || ss !== 5'h1f || rdata !== 16'habcd) begin
            errors++; $display("FAIL pot_done: done=%b err=%b gnt=%b ss=%h rdata=%h required 100/0/000/1f/abcd", done, err, gnt, ss, rdata);
        end
        @(negedge clk);
        checks++;
        if (done !== 3'b000) begin errors++; $display("FAIL pot_done_pulse: got %b required 000", done); end
        wait_idle();
    endtask

    task automatic test_contention();
        logic [2:0]  ctgt[3] = '{3'd0, 3'd4, 3'd3};
        logic [15:0] cdat[3] = '{16'ha000, 16'hb001, 16'hc002};
        logic [4:0]  css[3]  = '{5'h1e, 5'h0f, 5'h17};
        int order[4] = '{0, 1, 2, 0};
        int n, m;
        req_tgt = {ctgt[2], ctgt[1], ctgt[0]};
        req_data = {cdat[2], cdat[1], cdat[0]};
        req = 3'b111;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (ss === 5'h1f && n < 60) begin
                @(negedge clk);
                n++;
            end
            if (t > 0) begin
                checks++;
                if (n - 1 < GAP_CYC) begin errors++; $display("FAIL cont_gap%0d: got %0d required >=%0d", t, n - 1, GAP_CYC); end
            end
            checks++;
            if (gnt !== 3'(1 << order[t]) || ss !== css[order[t]]) begin
                errors++; $display("FAIL cont_grant%0d: gnt=%b ss=%h required %b/%h", t, gnt, ss, 3'(1 << order[t]), css[order[t]]);
            end
            wait_wrt(m);
            checks++;
            if (spi_cmd !== cdat[order[t]]) begin errors++; $display("FAIL cont_cmd%0d: got %h required %h", t, spi_cmd, cdat[order[t]]); end
            spi_frame(2, 16'h5a00 + 16'(t));
            wait_done(20, m);
            if (t == 3) req = 3'b000;
            checks++;
            if (done !== 3'(1 << order[t]) || err !== 1'b0) begin errors++; $display("FAIL cont_done%0d: done=%b err=%b required %b/0", t, done, err, 3'(1 << order[t])); end
        end
        wait_idle();
    endtask

    task automatic test_eeprom();
        int m;
        req = 3'b010; req_tgt[5:3] = 3'd4; req_data[31:16] = 16'h1200;
        wait_wrt(m);
        checks++;
        if (ss !== 5'h0f || spi_cmd !== 16'h1200 || gnt !== 3'b010) begin errors++; $display("FAIL eep_xfer: ss=%h cmd=%h gnt=%b required 0f/1200/010", ss, spi_cmd, gnt); end
        spi_frame(5, 16'h0034);
        wait_done(20, m);
        req = 3'b000;
        checks++;
        if (done !== 3'b010 || err !== 1'b0 || rdata !== 16'h0034) begin errors++; $display("FAIL eep_done: done=%b err=%b rdata=%h required 010/0/0034", done, err, rdata); end
        wait_idle();
    endtask

    task automatic test_invalid();
        req = 3'b001; req_tgt[2:0] = 3'd6;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b001 || done !== 3'b000 || ss !== 5'h1f) begin errors++; $display("FAIL inv_grant: gnt=%b done=%b ss=%h required 001/000/1f", gnt, done, ss); end
        @(negedge clk);
        req = 3'b000;
        checks++;
        if (done !== 3'b001 || err !== 1'b1 || ss !== 5'h1f || spi_wrt !== 1'b0 || rdata !== 16'h0034) begin
            errors++; $display("FAIL inv_reject: done=%b err=%b ss=%h wrt=%b rdata=%h required 001/1/1f/0/0034", done, err, ss, spi_wrt, rdata);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || done !== 3'b000) begin errors++; $display("FAIL inv_pulse: err=%b done=%b required 0/000", err, done); end
        wait_idle();
    endtask

    task automatic test_timeout();
        int m;
        req = 3'b100; req_tgt[8:6] = 3'd3; req_data[47:32] = 16'h0777;
        wait_wrt(m);
        @(negedge clk);
        checks++;
        if (ss !== 5'h17) begin errors++; $display("FAIL to_ss: got %h required 17", ss); end
        wait_done(TIMEOUT_CYC + 20, m);
        req = 3'b000;
        checks++;
        if (m != TIMEOUT_CYC - 1) begin errors++; $display("FAIL to_len: got %0d required %0d", m + 1, TIMEOUT_CYC); end
        checks++;
        if (done !== 3'b100 || err !== 1'b1 || ss !== 5'h1f || rdata !== 16'h0034) begin
            errors++; $display("FAIL to_done: done=%b err=%b ss=%h rdata=%h required 100/1/1f/0034", done, err, ss, rdata);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_xfer();
        int m;
        logic [2:0] acc;
        req = 3'b010; req_tgt[5:3] = 3'd4; req_data[31:16] = 16'h0300;
        wait_wrt(m);
        repeat (2) @(negedge clk);
        rst = 1'b1; req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ss !== 5'h1f || gnt !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid: ss=%h gnt=%b busy=%b required 1f/000/0", ss, gnt, busy); end
        acc = 3'b000;
        for (int i = 0; i < 12; i++) begin
            spi_done = (i == 3);
            @(negedge clk);
            acc |= done;
        end
        spi_done = 1'b0;
        checks++;
        if (acc !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL rst_nodone: done_seen=%b busy=%b required 000/0", acc, busy); end
        req = 3'b110; req_tgt[8:6] = 3'd2;
        @(negedge clk);
        checks++;
        if (gnt !== 3'b010) begin errors++; $display("FAIL rst_ptr: got %b required 010", gnt); end
        wait_wrt(m);
        spi_frame(2, 16'h0099);
        wait_done(20, m);
        req = 3'b000;
        checks++;
        if (done !== 3'b010 || rdata !== 16'h0099) begin errors++; $display("FAIL rst_after: done=%b rdata=%h required 010/0099", done, rdata); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_pot();
        test_contention();
        test_eeprom();
        test_invalid();
        test_timeout();
        test_reset_mid_xfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_bus_arb.md
Name: spi_bus_arb

Overview:
- Shares the one SPI master of the DSO digital core among three requesters: the boot-time calibration loader, the UART command processor's EEPROM path, and the gain/trigger-level pot writer.
- Grants requesters round-robin and steers the single 16-bit transaction to one of five slaves: ch1/ch2/ch3 gain pots, trigger-level pot, or calibration EEPROM.
- Sequences chip-select setup, hold and inter-frame gap around the SPI master.
- Sits between the requesters and the SPI master; drives the five active-low slave selects.

Parameters:
- SETUP_CYC, 4, clk cycles from SS_n low to spi_wrt pulse (range 1..255)
- HOLD_CYC, 4, clk cycles from spi_done to SS_n high (range 1..255)
- GAP_CYC, 8, clk cycles all SS_n high before next grant (range 1..255)
- TIMEOUT_CYC, 4096, clk cycles after spi_wrt without spi_done before abort (range 16..65535)

Ports:
- clk  in  1  system clock (400 MHz)
- rst  in  1  synchronous active-high reset
- req  in  3  request per requester; [0] cal loader, [1] cmd EEPROM, [2] pot writer
- req_tgt  in  9  3-bit target per requester, requester i at [3i+2:3i]; 0=ch1 pot, 1=ch2 pot, 2=ch3 pot, 3=trig pot, 4=EEPROM, 5-7 invalid
- req_data  in  48  16-bit SPI command per requester, requester i at [16i+15:16i]
- gnt  out  3  one-hot; the requester currently owning the bus
- done  out  3  one-cycle completion pulse for the granted requester
- err  out  1  one-cycle pulse coincident with done when the transaction was invalid or timed out
- rdata  out  16  data shifted in during the last transaction; valid from the done pulse until the next done
- busy  out  1  high in any state other than IDLE
- spi_wrt  out  1  one-cycle start pulse to the SPI master
- spi_cmd  out  16  command to the SPI master; held while the SS is low
- spi_done  in  1  SPI master frame complete
- spi_rdata  in  16  SPI master receive data; valid when spi_done is high
- ch1_ss_n, ch2_ss_n, ch3_ss_n, trig_ss_n, EEP_ss_n  out  1 each  active-low slave selects

Behaviour:
- Reset (sampled on the clk edge):
  - all *_ss_n = 1.
  - gnt, done, err, spi_wrt, busy = 0.
  - rdata = 0, spi_cmd = 0.
  - RR pointer = 0, state = IDLE.
  - A reset during any state aborts the transaction: SS_n is high on the cycle after the reset edge and no done is issued.
- All outputs are registered. At most one SS_n is low at any time. SS_n and gnt are never both changing to a new owner in the same cycle.
- IDLE:
  - If any req bit is set, pick the first set bit starting at the RR pointer and wrapping 0→1→2→0.
  - Register gnt, then latch that requester's req_tgt and req_data.
  - Set RR pointer = winner+1 mod 3.
  - Valid target → SETUP. Invalid target → REJECT.
- REJECT (1 cycle): done[winner] = 1, err = 1, no SS asserted, rdata unchanged. Then → GAP.
- SETUP: the selected SS_n is low and spi_cmd = latched data. Count SETUP_CYC cycles, then pulse spi_wrt for 1 cycle → XFER.
- XFER:
  - Wait for spi_done.
  - On spi_done, capture spi_rdata into rdata → HOLD.
  - If TIMEOUT_CYC cycles elapse first: raise SS_n on the next edge, pulse done[winner] and err, leave rdata unchanged → GAP.
- HOLD: count HOLD_CYC cycles, then raise SS_n, pulse done[winner] (err = 0), clear gnt → GAP.
- GAP: all SS_n high for GAP_CYC cycles → IDLE. Requests are not sampled during GAP.
- Minimum cycle count from grant to done for a valid transaction: 1 + SETUP_CYC + 1 + SPI frame + HOLD_CYC.
- Requester protocol:
  - Hold req, req_tgt and req_data stable until your done pulse.
  - Drop req within 1 cycle after done, or it re-enters arbitration at GAP end with rotated priority.
  - Deasserting req while granted has no effect; the transaction completes.
- Simultaneous requests are served in RR order, so no requester waits more than two other transactions.
- spi_done received outside XFER is ignored.
- Counters: 8-bit for setup/hold/gap, 16-bit for timeout; the timeout counter clears on entry to XFER.

Decomposition:
- Shared package dso_spi_pkg holds:
  - state enum: IDLE, REJECT, SETUP, XFER, HOLD, GAP
  - target encodings TGT_CH1=0, TGT_CH2=1, TGT_CH3=2, TGT_TRIG=3, TGT_EEP=4
  - requester indices REQ_CAL=0, REQ_CMD=1, REQ_POT=2
- One sub-module, rr_arb3: 3-way round-robin picker. Inputs: req, pointer. Outputs: winner one-hot, valid. Combinational, instantiated once.
- The FSM, counters and SS decode are in spi_bus_arb.

Test Plan:
- Single pot write: req[2] with tgt=1, data=16'h1234 → gnt=3'b100; ch2_ss_n low SETUP_CYC cycles before spi_wrt; spi_cmd=16'h1234; done[2] pulses HOLD_CYC cycles after spi_done; err=0; other SS_n stay high.
- Contention: req=3'b111 held, pointer=0 → grants in order 0,1,2. Keep req[0] asserted afterwards → next grant is 0 only after 2 has been served. Check gap ≥ GAP_CYC between consecutive SS_n lows.
- EEPROM read: req[1] with tgt=4, data=16'h1200; SPI model returns 16'h0034 → EEP_ss_n low for the frame; rdata=16'h0034 at done[1].
- Invalid target: req[0] with tgt=6 → no SS_n low, no spi_wrt; done[0] and err pulse together 1 cycle after grant.
- Timeout: req[2] with tgt=3, spi_done never asserted → trig_ss_n high, done[2] and err pulse TIMEOUT_CYC cycles after spi_wrt; arbiter returns to IDLE after GAP.
- Reset mid-XFER: rst=1 for 1 cycle during XFER → all SS_n high, gnt=0, busy=0 on the next cycle; no done pulse; a new request afterwards is granted normally starting from pointer 0.
